// File: rtl/pu_net_pkg.sv
// Packet layout helpers shared by the crossbar and the PU-side send/receive logic.
// The valid bit is the packet MSB; the destination field sits directly below it.
package pu_net_pkg;

    localparam int PKT_MAX_W = 64;
    localparam int VALID_OFS = 1;
    localparam int DST_OFS   = 2;

    // Widths are passed as arguments so one helper serves any PKT_W/NPU pairing.
    function automatic logic [31:0] dst_of(input logic [PKT_MAX_W-1:0] pkt,
                                           input int unsigned pkt_w,
                                           input int unsigned dst_w);
        logic [PKT_MAX_W-1:0] field;
        field = (pkt >> (pkt_w - DST_OFS - dst_w + 1))
              & ((PKT_MAX_W'(1) << dst_w) - PKT_MAX_W'(1));
        return field[31:0];
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Circular packet FIFO with occupancy count; head is registered storage, no bypass.
module pkt_fifo #(
    parameter int PKT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [PKT_W-1:0] pkt,
    output logic [PKT_W-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= pkt;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pu_xbar.sv
// Buffered NPU x NPU packet crossbar: per-source input FIFOs, per-destination
// round-robin arbitration over FIFO heads, registered single-cycle rx pulses.
module pu_xbar
    import pu_net_pkg::*;
#(
    parameter int NPU   = 4,
    parameter int PKT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPU*PKT_W-1:0] tx_in,
    output logic [NPU*PKT_W-1:0] rx_out,
    output logic [NPU-1:0]       full,
    output logic [NPU-1:0]       ovf,
    output logic [NPU-1:0]       bad_dst
);

    localparam int DST_W = $clog2(NPU);

    logic [PKT_W-1:0] tx       [NPU];
    logic [PKT_W-1:0] head     [NPU];
    logic [PKT_W-1:0] rx_q     [NPU];
    logic [31:0]      tx_dst   [NPU];
    logic [31:0]      head_dst [NPU];
    logic [NPU-1:0]   req      [NPU];
    logic [DST_W-1:0] ptr      [NPU];
    logic [DST_W-1:0] gnt_src  [NPU];
    logic [NPU-1:0]   gnt_vld;
    logic [NPU-1:0]   tx_vld;
    logic [NPU-1:0]   tx_legal;
    logic [NPU-1:0]   push;
    logic [NPU-1:0]   pop;
    logic [NPU-1:0]   empty;
    logic [NPU-1:0]   fifo_full;

    for (genvar i = 0; i < NPU; i++) begin : g_port
        assign tx[i]       = tx_in[i*PKT_W +: PKT_W];
        assign tx_dst[i]   = dst_of(PKT_MAX_W'(tx[i]), PKT_W, DST_W);
        assign head_dst[i] = dst_of(PKT_MAX_W'(head[i]), PKT_W, DST_W);
        assign tx_vld[i]   = tx[i][PKT_W-1];
        assign tx_legal[i] = (tx_dst[i] < 32'(NPU));
        assign push[i]     = tx_vld[i] & tx_legal[i] & ~fifo_full[i];
        assign rx_out[i*PKT_W +: PKT_W] = rx_q[i];

        pkt_fifo #(
            .PKT_W (PKT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .pkt   (tx[i]),
            .head  (head[i]),
            .empty (empty[i]),
            .full  (fifo_full[i])
        );
    end

    assign full = fifo_full;

    always_comb begin
        for (int j = 0; j < NPU; j++) begin
            for (int i = 0; i < NPU; i++) begin
                req[j][i] = ~empty[i] && (head_dst[i] == 32'(j));
            end
        end
    end

    // Search upward from ptr[j]; first hit wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < NPU; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_src[j] = '0;
            for (int k = 0; k < NPU; k++) begin
                idx = (int'(ptr[j]) + k) % NPU;
                if (!gnt_vld[j] && req[j][idx]) begin
                    gnt_vld[j] = 1'b1;
                    gnt_src[j] = DST_W'(idx);
                end
            end
        end
    end

    // A head addresses one output only, so no FIFO is popped twice.
    always_comb begin
        pop = '0;
        for (int j = 0; j < NPU; j++) begin
            if (gnt_vld[j]) begin
                pop[gnt_src[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NPU; j++) begin
                rx_q[j] <= '0;
                ptr[j]  <= '0;
            end
            ovf     <= '0;
            bad_dst <= '0;
        end else begin
            for (int j = 0; j < NPU; j++) begin
                if (gnt_vld[j]) begin
                    rx_q[j] <= head[gnt_src[j]];
                    ptr[j]  <= (gnt_src[j] == DST_W'(NPU - 1)) ? '0 : gnt_src[j] + 1'b1;
                end else begin
                    rx_q[j] <= '0;
                end
            end
            ovf     <= ovf | (tx_vld & tx_legal & fifo_full);
            bad_dst <= bad_dst | (tx_vld & ~tx_legal);
        end
    end

endmodule

// File: tb/tb_pu_xbar.sv
// Directed bench for pu_xbar: a 4-port instance for routing/arbitration/overflow
// and a 3-port instance for out-of-range destinations.
module tb_pu_xbar;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tx4;
    logic [127:0] rx4;
    logic [3:0]   full4, ovf4, bad4;
    logic [95:0]  tx3;
    logic [95:0]  rx3;
    logic [2:0]   full3, ovf3, bad3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pu_xbar #(.NPU(4), .PKT_W(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .tx_in(tx4), .rx_out(rx4),
        .full(full4), .ovf(ovf4), .bad_dst(bad4)
    );

    pu_xbar #(.NPU(3), .PKT_W(32), .DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .tx_in(tx3), .rx_out(rx3),
        .full(full3), .ovf(ovf3), .bad_dst(bad3)
    );

    typedef struct packed {
        logic [127:0] tx;
        logic [127:0] rx;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [31:0] pk(input logic [1:0] d, input logic [28:0] pl);
        return {1'b1, d, pl};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst2(input logic [28:0] base, input int o0, input int o1, input int o2);
        tx4 = {pk(2'd2, base + 29'd3), 32'h0, pk(2'd2, base + 29'd1), pk(2'd2, base)};
        step();
        tx4 = '0;
        chk("burst_t1", rx4, 128'h0);
        step();
        chk("burst_first", rx4, {32'h0, pk(2'd2, base + 29'(o0)), 64'h0});
        step();
        chk("burst_second", rx4, {32'h0, pk(2'd2, base + 29'(o1)), 64'h0});
        step();
        chk("burst_third", rx4, {32'h0, pk(2'd2, base + 29'(o2)), 64'h0});
        step();
        chk("burst_idle", rx4, 128'h0);
    endtask

    initial begin
        logic [7:0]  got_q [$];
        logic [31:0] r;
        logic [39:0] got;

        rst = 1'b1;
        tx4 = '0;
        tx3 = '0;

        vecs[0] = '{tx: {96'h0, pk(2'd2, 29'hABC)},
                    rx: {32'h0, pk(2'd2, 29'hABC), 64'h0}};
        vecs[1] = '{tx: {32'h0, pk(2'd2, 29'h0C), pk(2'd0, 29'h0B), pk(2'd1, 29'h0A)},
                    rx: {32'h0, pk(2'd2, 29'h0C), pk(2'd1, 29'h0A), pk(2'd0, 29'h0B)}};
        vecs[2] = '{tx: {pk(2'd3, 29'h33), pk(2'd0, 29'h20), 64'h0},
                    rx: {pk(2'd3, 29'h33), 64'h0, pk(2'd0, 29'h20)}};
        vecs[3] = '{tx: {pk(2'd0, 29'h30), pk(2'd1, 29'h21), pk(2'd2, 29'h12), pk(2'd3, 29'h03)},
                    rx: {pk(2'd3, 29'h03), pk(2'd2, 29'h12), pk(2'd1, 29'h21), pk(2'd0, 29'h30)}};
        vecs[4] = '{tx: {32'h5555_5555, 64'h0, 32'h7FFF_FFFF},
                    rx: 128'h0};

        // power-on reset
        step();
        step();
        chk("por_rx", rx4, 128'h0);
        chk("por_full", 128'(full4), 128'h0);
        chk("por_flags", 128'({ovf4, bad4, ovf3, bad3, full3}), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single-cycle uncontended vectors
        for (int i = 0; i < 5; i++) begin
            tx4 = vecs[i].tx;
            step();
            tx4 = '0;
            chk($sformatf("vec%0d_early", i), rx4, 128'h0);
            step();
            chk($sformatf("vec%0d_rx", i), rx4, vecs[i].rx);
            step();
            chk($sformatf("vec%0d_pulse", i), rx4, 128'h0);
            chk($sformatf("vec%0d_full", i), 128'(full4), 128'h0);
        end

        // out-of-range destination on the 3-port instance
        tx3 = {32'h0, pk(2'd3, 29'h77), 32'h0};
        step();
        tx3 = '0;
        chk("bad_rx_t1", 128'(rx3), 128'h0);
        chk("bad_flag", 128'(bad3), 128'h2);
        step();
        chk("bad_rx_t2", 128'(rx3), 128'h0);
        step();
        chk("bad_rx_t3", 128'(rx3), 128'h0);
        chk("bad_no_ovf", 128'(ovf3), 128'h0);
        tx3 = {64'h0, pk(2'd2, 29'h5A)};
        step();
        tx3 = '0;
        step();
        chk("n3_legal_rx", 128'(rx3), 128'({pk(2'd2, 29'h5A), 64'h0}));
        chk("bad_sticky", 128'(bad3), 128'h2);

        // reset in the middle of heavy traffic
        for (int k = 0; k < 8; k++) begin
            tx4 = {4{pk(2'd0, 29'(k))}};
            step();
        end
        chk("pre_rst_ovf", 128'(ovf4 != 4'h0), 128'h1);
        chk("pre_rst_full", 128'(full4 != 4'h0), 128'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rx", rx4, 128'h0);
        chk("rst_full", 128'(full4), 128'h0);
        chk("rst_ovf", 128'(ovf4), 128'h0);
        chk("rst_n3", 128'({bad3, ovf3, full3, rx3}), 128'h0);
        tx4 = '0;
        step();
        step();
        chk("rst_hold_rx", rx4, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        tx4 = {64'h0, pk(2'd3, 29'hBA5), 32'h0};
        step();
        tx4 = '0;
        chk("lat_early", rx4, 128'h0);
        step();
        chk("lat_rx", rx4, {pk(2'd3, 29'hBA5), 96'h0});
        step();
        chk("lat_pulse", rx4, 128'h0);

        // contention on output 2
        burst2(29'h100, 0, 1, 3);
        burst2(29'h200, 0, 1, 3);
        tx4 = {96'h0, pk(2'd2, 29'h2FF)};
        step();
        tx4 = '0;
        step();
        chk("ptr_set_rx", rx4, {32'h0, pk(2'd2, 29'h2FF), 64'h0});
        step();
        burst2(29'h300, 1, 3, 0);

        // overflow of FIFO 1 while output 3 is shared with three other sources
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc < 6) begin
                tx4 = {pk(2'd3, 29'h300 + 29'(cyc)), pk(2'd3, 29'h200 + 29'(cyc)),
                       pk(2'd3, 29'h100 + 29'(cyc + 1)), pk(2'd3, 29'(cyc))};
            end else begin
                tx4 = '0;
            end
            step();
            if (cyc == 2) chk("ovf_not_full_yet", 128'(full4[1]), 128'h0);
            if (cyc == 3) begin
                chk("ovf_full_after4", 128'(full4[1]), 128'h1);
                chk("ovf_flag_clear", 128'(ovf4[1]), 128'h0);
            end
            if (cyc == 4) begin
                chk("ovf_flag_set", 128'(ovf4[1]), 128'h1);
                chk("ovf_pop_rejects_push", 128'(full4[1]), 128'h0);
            end
            if (cyc == 5) chk("ovf_refull", 128'(full4[1]), 128'h1);
            r = rx4[127:96];
            if (r[31] && r[11:8] == 4'h1) got_q.push_back(r[7:0]);
        end
        chk("ovf_count", 128'(got_q.size()), 128'd5);
        got = '0;
        if (got_q.size() == 5) got = {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4]};
        chk("ovf_order", 128'(got), 128'h01_02_03_04_06);
        chk("ovf_drained", rx4, 128'h0);
        chk("ovf_sticky", 128'(ovf4[1]), 128'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
